// File: rtl/seq_pkg.sv
// Shared types and encodings for the multi-cycle fetch/decode/execute sequencer.
// Used by seq_decode and multicycle_sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_ALU   = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_JMP   = 3'd4,
        CLS_BRZ   = 3'd5,
        CLS_HALT  = 3'd6
    } instr_cls_e;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_BRZ   = 4'h9;
    localparam logic [3:0] OP_LOAD  = 4'hC;
    localparam logic [3:0] OP_STORE = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode classifier: ir[7:4] -> instruction class and ALU operation.
// SEQ_BRANCH_EN decides whether opcode 1001 is BRZ or a NOP.
module seq_decode
    import seq_pkg::*;
(
    input  logic [3:0]  opcode,
    output instr_cls_e  cls,
    output logic [2:0]  alu_op
);

    always_comb begin
        cls    = CLS_NOP;
        alu_op = ALU_ADD;
        case (opcode)
            OP_ADD: begin
                cls    = CLS_ALU;
                alu_op = ALU_ADD;
            end
            OP_SUB: begin
                cls    = CLS_ALU;
                alu_op = ALU_SUB;
            end
            OP_AND: begin
                cls    = CLS_ALU;
                alu_op = ALU_AND;
            end
            OP_LOAD:  cls = CLS_LOAD;
            OP_STORE: cls = CLS_STORE;
            OP_JMP:   cls = CLS_JMP;
`ifdef SEQ_BRANCH_EN
            OP_BRZ:   cls = CLS_BRZ;
`else
            OP_BRZ:   cls = CLS_NOP;
`endif
            OP_HALT:  cls = CLS_HALT;
            default:  cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer owning pc, ir and the shared memory port.
// Optional macro SEQ_BRANCH_EN enables the BRZ (branch if zero_flag) instruction.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    // Memory port: a request is held with stable we/addr until the edge where mem_req && mem_ack.
    output logic            mem_req,
    output logic            mem_we,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    input  logic            zero_flag,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ir,
    output logic [2:0]      alu_op,
    output logic            reg_write,
    output logic            mem_read_done,
    output logic            halted,
    output logic [2:0]      dbg_state
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;

    instr_cls_e      dec_cls;
    logic [2:0]      dec_alu_op;
    logic [PC_W-1:0] operand_ext;
    logic            branch_taken;

    seq_decode u_decode (
        .opcode (ir_q[7:4]),
        .cls    (dec_cls),
        .alu_op (dec_alu_op)
    );

    assign operand_ext = PC_W'(ir_q[3:0]);

`ifdef SEQ_BRANCH_EN
    assign branch_taken = zero_flag;
`else
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;
    assign branch_taken     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = pc_q;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        mem_read_done = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_DECODE;
                end
            end

            // pc already points past this instruction, so untaken branches and NOPs leave it alone.
            ST_DECODE: begin
                case (dec_cls)
                    CLS_ALU:   state_d = ST_EXEC;
                    CLS_LOAD:  state_d = ST_MEM;
                    CLS_STORE: state_d = ST_MEM;
                    CLS_JMP: begin
                        pc_d    = operand_ext;
                        state_d = ST_FETCH;
                    end
                    CLS_BRZ: begin
                        if (branch_taken) begin
                            pc_d = operand_ext;
                        end
                        state_d = ST_FETCH;
                    end
                    CLS_HALT:  state_d = ST_HALT;
                    default:   state_d = ST_FETCH;
                endcase
            end

            ST_EXEC: begin
                alu_op    = dec_alu_op;
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end

            ST_MEM: begin
                mem_req  = 1'b1;
                mem_we   = (dec_cls == CLS_STORE);
                mem_addr = operand_ext;
                if (mem_ack) begin
                    if (dec_cls == CLS_LOAD) begin
                        reg_write     = 1'b1;
                        mem_read_done = 1'b1;
                    end
                    state_d = ST_FETCH;
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign pc        = pc_q;
    assign ir        = ir_q;
    assign halted    = (state_q == ST_HALT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer (PC_W=4): directed scenarios plus random
// programs checked against an instruction-level reference model with random memory latency.
module tb_multicycle_sequencer;

    localparam int PC_W    = 4;
    localparam int MEM_N   = 1 << PC_W;
    localparam int MAX_CYC = 1024;
`ifdef SEQ_BRANCH_EN
    localparam bit BRZ_EN = 1'b1;
`else
    localparam bit BRZ_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mem_req;
    logic            mem_we;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ack = 1'b0;
    logic [7:0]      mem_rdata = 8'h00;
    logic            zero_flag = 1'b0;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic [2:0]      alu_op;
    logic            reg_write;
    logic            mem_read_done;
    logic            halted;
    logic [2:0]      dbg_state;

    multicycle_sequencer #(.PC_W(PC_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .zero_flag     (zero_flag),
        .pc            (pc),
        .ir            (ir),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .mem_read_done (mem_read_done),
        .halted        (halted),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory image, latency plan, observation ----------------
    logic [7:0]      mem [MEM_N];
    int              w_list [256];
    int              resp_idx;
    int              wait_left;
    bit              busy;

    int              cyc;
    int              log_limit;
    logic [15:0]     obs_q[$];
    logic [15:0]     exp_q[$];
    logic            req_a [MAX_CYC];
    logic            we_a [MAX_CYC];
    logic            rw_a [MAX_CYC];
    logic            mrd_a [MAX_CYC];
    logic            halted_a [MAX_CYC];
    logic [PC_W-1:0] addr_a [MAX_CYC];
    logic [PC_W-1:0] pc_a [MAX_CYC];
    logic [2:0]      alu_a [MAX_CYC];
    int              first_halt;
    int              rw_twice;
    int              req_in_halt;
    logic            prev_rw;

    int              vectors;
    int              miscompares;

    // Memory responder and per-cycle monitor, both acting on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n || !mem_req) begin
            mem_ack = 1'b0;
            busy    = 1'b0;
        end else begin
            if (mem_ack) busy = 1'b0;
            if (!busy) begin
                busy      = 1'b1;
                wait_left = (resp_idx < 256) ? w_list[resp_idx] : 0;
                resp_idx++;
            end
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                mem_ack   = 1'b0;
                wait_left--;
            end
        end
        #1;
        if (rst_n && cyc < MAX_CYC - 1) begin
            cyc++;
            req_a[cyc]    = mem_req;
            we_a[cyc]     = mem_we;
            addr_a[cyc]   = mem_addr;
            rw_a[cyc]     = reg_write;
            mrd_a[cyc]    = mem_read_done;
            alu_a[cyc]    = alu_op;
            pc_a[cyc]     = pc;
            halted_a[cyc] = halted;
            if (cyc <= log_limit) begin
                if (mem_req && mem_ack)
                    obs_q.push_back({4'h1, 3'b000, mem_we, 8'(mem_addr)});
                if (reg_write || mem_read_done)
                    obs_q.push_back({4'h2, 3'b000, mem_read_done, 5'b00000, alu_op});
            end
            if (reg_write && prev_rw) rw_twice++;
            if (halted && mem_req) req_in_halt++;
            if (halted && first_halt == 0) first_halt = cyc;
            prev_rw = reg_write;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < MEM_N; i++) mem[i] = v;
    endtask

    task automatic clear_waits();
        for (int i = 0; i < 256; i++) w_list[i] = 0;
    endtask

    task automatic do_reset(input logic zf);
        rst_n = 1'b0;
        zero_flag = zf;
        @(negedge clk);
        #2;
        cyc = 0; resp_idx = 0; first_halt = 0; rw_twice = 0; req_in_halt = 0; prev_rw = 1'b0;
        obs_q.delete();
        for (int i = 0; i < MAX_CYC; i++) begin
            req_a[i] = 1'b0; we_a[i] = 1'b0; rw_a[i] = 1'b0; mrd_a[i] = 1'b0;
            halted_a[i] = 1'b0; addr_a[i] = '0; pc_a[i] = '0; alu_a[i] = '0;
        end
        rst_n = 1'b1;
    endtask

    task automatic run_until(input int limit);
        int guard = 0;
        while (cyc < limit && guard < MAX_CYC) begin
            @(negedge clk);
            #2;
            guard++;
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    // Walks the program one instruction at a time, consuming the latency plan in request order.
    task automatic model_run(input int n_instr, input logic zf, output int total, output int halt_at);
        int p = 0;
        int c = 0;
        int k = 0;
        int w;
        logic [7:0] ins;
        logic [3:0] op;
        logic [3:0] opd;
        exp_q.delete();
        halt_at = 0;
        for (int i = 0; i < n_instr; i++) begin
            w = (k < 256) ? w_list[k] : 0; k++;
            exp_q.push_back({4'h1, 3'b000, 1'b0, 8'(p)});
            ins = mem[p];
            p = (p + 1) % MEM_N;
            c += 2 + w;
            op = ins[7:4];
            opd = ins[3:0];
            if (op <= 4'h2) begin
                exp_q.push_back({4'h2, 3'b000, 1'b0, 5'b00000, op[2:0]});
                c += 1;
            end else if (op == 4'hC) begin
                w = (k < 256) ? w_list[k] : 0; k++;
                exp_q.push_back({4'h1, 3'b000, 1'b0, 8'(opd)});
                exp_q.push_back({4'h2, 3'b000, 1'b1, 5'b00000, 3'b000});
                c += 1 + w;
            end else if (op == 4'hE) begin
                w = (k < 256) ? w_list[k] : 0; k++;
                exp_q.push_back({4'h1, 3'b000, 1'b1, 8'(opd)});
                c += 1 + w;
            end else if (op == 4'h8) begin
                p = opd;
            end else if (op == 4'h9 && BRZ_EN && zf) begin
                p = opd;
            end else if (op == 4'hF) begin
                halt_at = c + 1;
                break;
            end
        end
        total = c;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
        vectors++; if (pc !== '0) begin miscompares++; $display("FAIL reset_pc: got %0h exp 0", pc); end
        vectors++; if (ir !== 8'h00) begin miscompares++; $display("FAIL reset_ir: got %0h exp 0", ir); end
        vectors++; if (reg_write !== 1'b0 || mem_read_done !== 1'b0) begin miscompares++; $display("FAIL reset_strobes: got %b%b exp 00", reg_write, mem_read_done); end
        vectors++; if (alu_op !== 3'b000) begin miscompares++; $display("FAIL reset_alu_op: got %0b exp 000", alu_op); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b exp 0", halted); end
    endtask

    task automatic test_add();
        int total, halt_at;
        fill_mem(8'hF0); clear_waits();
        mem[0] = 8'h05;
        model_run(10, 1'b0, total, halt_at);
        log_limit = halt_at + 5;
        do_reset(1'b0);
        run_until(log_limit);
        vectors++; if (req_a[1] !== 1'b1 || addr_a[1] !== 4'h0 || we_a[1] !== 1'b0) begin miscompares++; $display("FAIL add_fetch: got req=%b addr=%0h we=%b exp 1/0/0", req_a[1], addr_a[1], we_a[1]); end
        vectors++; if (rw_a[1] !== 1'b0 || rw_a[2] !== 1'b0) begin miscompares++; $display("FAIL add_early_rw: got %b%b exp 00", rw_a[1], rw_a[2]); end
        vectors++; if (rw_a[3] !== 1'b1 || alu_a[3] !== 3'b000) begin miscompares++; $display("FAIL add_exec: got rw=%b alu=%0b exp 1/000", rw_a[3], alu_a[3]); end
        vectors++; if (pc_a[3] !== 4'h1) begin miscompares++; $display("FAIL add_pc: got %0h exp 1", pc_a[3]); end
        vectors++; if (req_a[4] !== 1'b1 || addr_a[4] !== 4'h1) begin miscompares++; $display("FAIL add_next_fetch: got req=%b addr=%0h exp 1/1", req_a[4], addr_a[4]); end
        vectors++; if (first_halt !== 6 || first_halt !== halt_at) begin miscompares++; $display("FAIL add_halt_cycle: got %0d exp 6 (model %0d)", first_halt, halt_at); end
    endtask

    task automatic test_load_wait();
        int total, halt_at;
        fill_mem(8'hF0); clear_waits();
        mem[0] = 8'hB0; mem[1] = 8'hC7; mem[7] = 8'h5A;
        w_list[2] = 2;
        model_run(10, 1'b0, total, halt_at);
        log_limit = halt_at + 5;
        do_reset(1'b0);
        run_until(log_limit);
        for (int n = 5; n <= 7; n++) begin
            vectors++; if (req_a[n] !== 1'b1 || addr_a[n] !== 4'h7 || we_a[n] !== 1'b0) begin miscompares++; $display("FAIL load_hold c%0d: got req=%b addr=%0h we=%b exp 1/7/0", n, req_a[n], addr_a[n], we_a[n]); end
        end
        vectors++; if (rw_a[5] !== 1'b0 || rw_a[6] !== 1'b0 || mrd_a[5] !== 1'b0 || mrd_a[6] !== 1'b0) begin miscompares++; $display("FAIL load_wait_strobe: got rw=%b%b mrd=%b%b exp 00/00", rw_a[5], rw_a[6], mrd_a[5], mrd_a[6]); end
        vectors++; if (rw_a[7] !== 1'b1 || mrd_a[7] !== 1'b1) begin miscompares++; $display("FAIL load_ack_strobe: got rw=%b mrd=%b exp 1/1", rw_a[7], mrd_a[7]); end
        vectors++; if (rw_a[8] !== 1'b0 || mrd_a[8] !== 1'b0 || addr_a[8] !== 4'h2) begin miscompares++; $display("FAIL load_after: got rw=%b mrd=%b addr=%0h exp 0/0/2", rw_a[8], mrd_a[8], addr_a[8]); end
        vectors++; if (first_halt !== halt_at) begin miscompares++; $display("FAIL load_halt_cycle: got %0d exp %0d", first_halt, halt_at); end
    endtask

    task automatic test_store_halt();
        int total, halt_at;
        fill_mem(8'hF0); clear_waits();
        mem[0] = 8'hE3; mem[1] = 8'hF0;
        model_run(10, 1'b0, total, halt_at);
        log_limit = halt_at + 20;
        do_reset(1'b0);
        run_until(log_limit);
        vectors++; if (req_a[3] !== 1'b1 || we_a[3] !== 1'b1 || addr_a[3] !== 4'h3) begin miscompares++; $display("FAIL store_req: got req=%b we=%b addr=%0h exp 1/1/3", req_a[3], we_a[3], addr_a[3]); end
        vectors++; if (rw_a[3] !== 1'b0 || mrd_a[3] !== 1'b0) begin miscompares++; $display("FAIL store_strobe: got %b%b exp 00", rw_a[3], mrd_a[3]); end
        vectors++; if (halted_a[5] !== 1'b0 || halted_a[6] !== 1'b1) begin miscompares++; $display("FAIL store_halted: got %b%b exp 01", halted_a[5], halted_a[6]); end
        vectors++; if (first_halt !== halt_at) begin miscompares++; $display("FAIL store_halt_cycle: got %0d exp %0d", first_halt, halt_at); end
        vectors++; if (req_in_halt !== 0 || halted_a[log_limit] !== 1'b1) begin miscompares++; $display("FAIL halt_quiet: got req_cycles=%0d halted=%b exp 0/1", req_in_halt, halted_a[log_limit]); end
    endtask

    task automatic test_jmp_wrap();
        int total, halt_at;
        fill_mem(8'hB0); clear_waits();
        mem[0] = 8'h8A; mem[10] = 8'h8F; mem[15] = 8'h00;
        model_run(8, 1'b0, total, halt_at);
        log_limit = total;
        do_reset(1'b0);
        run_until(log_limit);
        vectors++; if (addr_a[3] !== 4'hA || req_a[3] !== 1'b1) begin miscompares++; $display("FAIL jmp_target: got addr=%0h req=%b exp A/1", addr_a[3], req_a[3]); end
        vectors++; if (addr_a[5] !== 4'hF || pc_a[5] !== 4'hF) begin miscompares++; $display("FAIL jmp_to_15: got addr=%0h pc=%0h exp F/F", addr_a[5], pc_a[5]); end
        vectors++; if (pc_a[6] !== 4'h0) begin miscompares++; $display("FAIL pc_wrap: got %0h exp 0", pc_a[6]); end
        vectors++; if (rw_a[7] !== 1'b1 || addr_a[8] !== 4'h0) begin miscompares++; $display("FAIL wrap_exec: got rw=%b next_addr=%0h exp 1/0", rw_a[7], addr_a[8]); end
        vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL jmp_event_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_brz(input logic zf);
        int total, halt_at;
        logic [PC_W-1:0] exp_addr;
        fill_mem(8'hF0); clear_waits();
        mem[0] = 8'h94;
        exp_addr = (BRZ_EN && zf) ? 4'h4 : 4'h1;
        model_run(10, zf, total, halt_at);
        log_limit = halt_at + 5;
        do_reset(zf);
        run_until(log_limit);
        vectors++; if (addr_a[3] !== exp_addr || req_a[3] !== 1'b1) begin miscompares++; $display("FAIL brz_zf%b_target: got addr=%0h req=%b exp %0h/1", zf, addr_a[3], req_a[3], exp_addr); end
        vectors++; if (rw_a[2] !== 1'b0 || req_a[2] !== 1'b0) begin miscompares++; $display("FAIL brz_zf%b_decode: got rw=%b req=%b exp 0/0", zf, rw_a[2], req_a[2]); end
        vectors++; if (first_halt !== 5 || first_halt !== halt_at) begin miscompares++; $display("FAIL brz_zf%b_halt: got %0d exp 5 (model %0d)", zf, first_halt, halt_at); end
    endtask

    task automatic test_reset_mid();
        int total, halt_at;
        fill_mem(8'hF0); clear_waits();
        mem[0] = 8'h05;
        w_list[1] = 5;
        log_limit = 0;
        do_reset(1'b0);
        run_until(5);
        #1;
        vectors++; if (mem_req !== 1'b1 || mem_ack !== 1'b0 || pc !== 4'h1) begin miscompares++; $display("FAIL mid_pre: got req=%b ack=%b pc=%0h exp 1/0/1", mem_req, mem_ack, pc); end
        rst_n = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_req_drop: got %b exp 0", mem_req); end
        vectors++; if (pc !== 4'h0 || ir !== 8'h00) begin miscompares++; $display("FAIL mid_regs: got pc=%0h ir=%0h exp 0/0", pc, ir); end
        clear_waits();
        model_run(10, 1'b0, total, halt_at);
        log_limit = halt_at + 5;
        do_reset(1'b0);
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_boot: got req=%b exp 0", mem_req); end
        run_until(log_limit);
        vectors++; if (req_a[1] !== 1'b1 || addr_a[1] !== 4'h0 || pc_a[1] !== 4'h0) begin miscompares++; $display("FAIL mid_refetch: got req=%b addr=%0h pc=%0h exp 1/0/0", req_a[1], addr_a[1], pc_a[1]); end
        vectors++; if (first_halt !== halt_at) begin miscompares++; $display("FAIL mid_halt_cycle: got %0d exp %0d", first_halt, halt_at); end
    endtask

    task automatic test_random(input int runs);
        logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h2, 4'h8, 4'h9, 4'hC, 4'hE, 4'hF, 4'hB, 4'h3};
        int total, halt_at;
        logic zf;
        for (int r = 0; r < runs; r++) begin
            for (int i = 0; i < MEM_N; i++) mem[i] = {ops[$urandom_range(9, 0)], 4'($urandom_range(15, 0))};
            for (int i = 0; i < 256; i++) w_list[i] = $urandom_range(3, 0);
            zf = 1'($urandom_range(1, 0));
            model_run(40, zf, total, halt_at);
            log_limit = (halt_at != 0) ? halt_at + 20 : total;
            do_reset(zf);
            run_until(log_limit);
            vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rand%0d_count: got %0d exp %0d", r, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand%0d_event%0d: got %04h exp %04h", r, i, obs_q[i], exp_q[i]); end
            end
            vectors++; if (first_halt !== halt_at) begin miscompares++; $display("FAIL rand%0d_halt: got %0d exp %0d", r, first_halt, halt_at); end
            vectors++; if (rw_twice !== 0 || req_in_halt !== 0) begin miscompares++; $display("FAIL rand%0d_rules: got rw_twice=%0d req_in_halt=%0d exp 0/0", r, rw_twice, req_in_halt); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors = 0; miscompares = 0; log_limit = 0; cyc = 0;
        resp_idx = 0; wait_left = 0; busy = 1'b0; prev_rw = 1'b0;
        first_halt = 0; rw_twice = 0; req_in_halt = 0;
        fill_mem(8'hF0);
        clear_waits();
        test_reset();
        test_add();
        test_load_wait();
        test_store_halt();
        test_jmp_wrap();
        test_brz(1'b1);
        test_brz(1'b0);
        test_reset_mid();
        test_random(8);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
